// File: rtl/gate_scheduler_cba.sv
// Gate scheduler for the CBA datapath: buffers one stabilizer tableau plus a gate FIFO,
// streams the tableau through the CBA unit once per queued gate, then drains the result.
module gate_scheduler_cba #(
    parameter int num_qubit  = 4,
    parameter int gate_depth = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gate_valid_in,
    output logic                   gate_ready_out,
    input  logic [2:0]             gate_type_in,
    input  logic [31:0]            gate_pos_in,
    input  logic [31:0]            gate_pos2_in,
    output logic                   gate_err_out,
    input  logic                   tab_valid_in,
    output logic                   tab_ready_out,
    input  logic [2*num_qubit:0]   tab_row_in,
    input  logic                   start_in,
    output logic                   cba_valid_out,
    output logic [2*num_qubit:0]   cba_row_out,
    output logic [2:0]             cba_gate_type,
    output logic [31:0]            cba_qubit_pos,
    output logic [31:0]            cba_qubit_pos2,
    input  logic                   cba_valid_in,
    input  logic [2*num_qubit:0]   cba_row_in,
    output logic                   res_valid_out,
    output logic [2*num_qubit:0]   res_row_out,
    output logic                   res_last_out,
    output logic                   done_out,
    output logic                   busy_out,
    output logic [15:0]            gates_done_out
);

    localparam int RW = 2 * num_qubit + 1;
    localparam int IW = $clog2(num_qubit);
    localparam int AW = $clog2(gate_depth);
    localparam int CW = AW + 1;
    localparam int GW = 67;
    localparam logic [IW-1:0] LAST_ROW = IW'(num_qubit - 1);
    localparam logic [CW-1:0] FULL     = CW'(gate_depth);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] HOLD    = 3'd2;
    localparam logic [2:0] ISSUE   = 3'd3;
    localparam logic [2:0] COLLECT = 3'd4;
    localparam logic [2:0] DRAIN   = 3'd5;
    localparam logic [2:0] FIN     = 3'd6;

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [RW-1:0] rows [num_qubit];
    logic [GW-1:0] fifo_mem [gate_depth];
    logic [GW-1:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic push;
    logic legal;
    logic push_wr;
    logic pop;
    logic tab_acc;
    logic fifo_empty;
    logic last_idx;
    logic collect_done;

    // Illegal gates would hang the CBA unit in its load state, so they never enter the FIFO.
    function automatic logic gate_legal(input logic [2:0] t, input logic [31:0] p,
                                        input logic [31:0] p2);
        gate_legal = (t <= 3'd2) && (p < 32'(num_qubit)) &&
                     ((t != 3'd2) || ((p2 < 32'(num_qubit)) && (p2 != p)));
    endfunction

    assign gate_ready_out = (count != FULL);
    assign tab_ready_out  = (state == IDLE) || (state == LOAD);
    assign push           = gate_valid_in && gate_ready_out;
    assign legal          = gate_legal(gate_type_in, gate_pos_in, gate_pos2_in);
    assign push_wr        = push && legal;
    assign tab_acc        = tab_valid_in && tab_ready_out;
    assign fifo_empty     = (count == '0);
    assign last_idx       = (idx == LAST_ROW);
    assign collect_done   = (state == COLLECT) && cba_valid_in && last_idx;
    assign pop            = !fifo_empty && (((state == HOLD) && start_in) || collect_done);
    assign head           = fifo_mem[rd_ptr];

    // Storage arrays carry no reset; their contents are don't-care after an abort.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            fifo_mem[wr_ptr] <= {gate_type_in, gate_pos_in, gate_pos2_in};
        end
        if (tab_acc) begin
            rows[idx] <= tab_row_in;
        end else if ((state == COLLECT) && cba_valid_in) begin
            rows[idx] <= cba_row_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            gate_err_out   <= 1'b0;
            cba_valid_out  <= 1'b0;
            cba_row_out    <= '0;
            cba_gate_type  <= '0;
            cba_qubit_pos  <= '0;
            cba_qubit_pos2 <= '0;
            res_valid_out  <= 1'b0;
            res_row_out    <= '0;
            res_last_out   <= 1'b0;
            done_out       <= 1'b0;
            busy_out       <= 1'b0;
            gates_done_out <= '0;
        end else begin
            gate_err_out  <= push && !legal;
            cba_valid_out <= 1'b0;
            res_valid_out <= 1'b0;
            res_last_out  <= 1'b0;
            done_out      <= 1'b0;

            if (push_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + AW'(1);
                cba_gate_type  <= head[GW-1:64];
                cba_qubit_pos  <= head[63:32];
                cba_qubit_pos2 <= head[31:0];
            end
            count <= count + CW'(push_wr) - CW'(pop);

            case (state)
                IDLE: begin
                    if (tab_acc) begin
                        state          <= LOAD;
                        idx            <= IW'(1);
                        gates_done_out <= '0;
                        busy_out       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (tab_acc) begin
                        if (last_idx) begin
                            state <= HOLD;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (start_in) begin
                        idx   <= '0;
                        state <= fifo_empty ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    cba_valid_out <= 1'b1;
                    cba_row_out   <= rows[idx];
                    if (last_idx) begin
                        state <= COLLECT;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                COLLECT: begin
                    if (cba_valid_in) begin
                        if (last_idx) begin
                            idx   <= '0;
                            state <= fifo_empty ? DRAIN : ISSUE;
                            if (gates_done_out != 16'hFFFF) begin
                                gates_done_out <= gates_done_out + 16'd1;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    res_valid_out <= 1'b1;
                    res_row_out   <= rows[idx];
                    res_last_out  <= last_idx;
                    if (last_idx) begin
                        state <= FIN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                FIN: begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_scheduler_cba.sv
// Self-checking bench for gate_scheduler_cba: a behavioural CBA responder plus a
// whole-tableau Clifford reference model, driven by tables, hand sequences and random runs.
module tb_gate_scheduler_cba;

    localparam int NQ = 4;
    localparam int GD = 8;
    localparam int RW = 2 * NQ + 1;

    typedef struct packed {
        logic [2:0]  t;
        logic [31:0] p;
        logic [31:0] p2;
    } gate_t;

    typedef struct packed {
        gate_t g;
        logic  err;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          gate_valid_in;
    logic          gate_ready_out;
    logic [2:0]    gate_type_in;
    logic [31:0]   gate_pos_in;
    logic [31:0]   gate_pos2_in;
    logic          gate_err_out;
    logic          tab_valid_in;
    logic          tab_ready_out;
    logic [RW-1:0] tab_row_in;
    logic          start_in;
    logic          cba_valid_out;
    logic [RW-1:0] cba_row_out;
    logic [2:0]    cba_gate_type;
    logic [31:0]   cba_qubit_pos;
    logic [31:0]   cba_qubit_pos2;
    logic          cba_valid_in;
    logic [RW-1:0] cba_row_in;
    logic          res_valid_out;
    logic [RW-1:0] res_row_out;
    logic          res_last_out;
    logic          done_out;
    logic          busy_out;
    logic [15:0]   gates_done_out;

    logic          stub_valid;
    logic [RW-1:0] stub_row;
    logic          stray_valid;
    logic [RW-1:0] stray_row;

    assign cba_valid_in = stub_valid | stray_valid;
    assign cba_row_in   = stray_valid ? stray_row : stub_row;

    gate_scheduler_cba #(.num_qubit(NQ), .gate_depth(GD)) dut (
        .clk(clk), .rst(rst),
        .gate_valid_in(gate_valid_in), .gate_ready_out(gate_ready_out),
        .gate_type_in(gate_type_in), .gate_pos_in(gate_pos_in), .gate_pos2_in(gate_pos2_in),
        .gate_err_out(gate_err_out),
        .tab_valid_in(tab_valid_in), .tab_ready_out(tab_ready_out), .tab_row_in(tab_row_in),
        .start_in(start_in),
        .cba_valid_out(cba_valid_out), .cba_row_out(cba_row_out),
        .cba_gate_type(cba_gate_type), .cba_qubit_pos(cba_qubit_pos),
        .cba_qubit_pos2(cba_qubit_pos2),
        .cba_valid_in(cba_valid_in), .cba_row_in(cba_row_in),
        .res_valid_out(res_valid_out), .res_row_out(res_row_out), .res_last_out(res_last_out),
        .done_out(done_out), .busy_out(busy_out), .gates_done_out(gates_done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    gate_t         ref_q [$];
    logic [RW-1:0] exp_tab [NQ];
    logic [RW-1:0] got_rows [NQ];
    int            base_iss, base_res, base_done;

    gate_t         iss_q [$];
    logic [RW-1:0] res_q [$];
    logic          last_q [$];
    int            done_cnt = 0;
    int            done_bad = 0;
    int            held_bad = 0;
    int            runlen_bad = 0;
    int            resrun_bad = 0;

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic legal(input gate_t g);
        return (g.t <= 3'd2) && (g.p < 32'(NQ)) &&
               ((g.t != 3'd2) || ((g.p2 < 32'(NQ)) && (g.p2 != g.p)));
    endfunction

    // Clifford conjugation of one Pauli row {phase, x, z} (Aaronson-Gottesman update rules).
    function automatic logic [RW-1:0] apply_row(input logic [RW-1:0] r, input gate_t g);
        logic          ph;
        logic [NQ-1:0] x;
        logic [NQ-1:0] z;
        logic          tmp;
        int            a;
        int            b;
        ph = r[RW-1];
        x  = r[2*NQ-1:NQ];
        z  = r[NQ-1:0];
        a  = int'(g.p % NQ);
        b  = int'(g.p2 % NQ);
        case (g.t)
            3'd0: begin ph ^= x[a] & z[a]; tmp = x[a]; x[a] = z[a]; z[a] = tmp; end
            3'd1: begin ph ^= x[a] & z[a]; z[a] ^= x[a]; end
            3'd2: begin ph ^= x[a] & z[b] & ~(x[b] ^ z[a]); x[b] ^= x[a]; z[a] ^= z[b]; end
            default: ;
        endcase
        return {ph, x, z};
    endfunction

    // Behavioural CBA unit: gathers a whole tableau pass, then returns it after a random pause.
    initial begin : cba_stub
        logic [RW-1:0] pend [$];
        logic          sending;
        int            wait_c;
        gate_t         hg;
        stub_valid = 1'b0;
        stub_row   = '0;
        sending    = 1'b0;
        wait_c     = 0;
        forever begin
            @(posedge clk);
            #1;
            stub_valid = 1'b0;
            if (rst) begin
                pend.delete();
                sending = 1'b0;
            end else begin
                if (cba_valid_out) begin
                    hg = '{t: cba_gate_type, p: cba_qubit_pos, p2: cba_qubit_pos2};
                    pend.push_back(apply_row(cba_row_out, hg));
                end
                if (!sending && pend.size() == NQ) begin
                    sending = 1'b1;
                    wait_c  = $urandom_range(0, 3);
                end
                if (sending) begin
                    if (wait_c > 0) begin
                        wait_c--;
                    end else if ($urandom_range(0, 3) != 0) begin
                        stub_valid = 1'b1;
                        stub_row   = pend.pop_front();
                        if (pend.size() == 0) sending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic  prev_cv, prev_last, prev_rv;
        gate_t prev_g, cur;
        int    runlen, resrun;
        prev_cv = 1'b0; prev_last = 1'b0; prev_rv = 1'b0; prev_g = '0;
        runlen = 0; resrun = 0;
        forever begin
            @(negedge clk);
            cur = '{t: cba_gate_type, p: cba_qubit_pos, p2: cba_qubit_pos2};
            if (cba_valid_out) begin
                if (!prev_cv) begin
                    iss_q.push_back(cur);
                    runlen = 1;
                end else begin
                    runlen++;
                end
                if (cur != prev_g) held_bad++;
            end else if (prev_cv && runlen != NQ) begin
                runlen_bad++;
            end
            if (res_valid_out) begin
                res_q.push_back(res_row_out);
                last_q.push_back(res_last_out);
                resrun = prev_rv ? resrun + 1 : 1;
            end else if (prev_rv && resrun != NQ) begin
                resrun_bad++;
            end
            if (done_out) begin
                done_cnt++;
                if (!prev_last) done_bad++;
            end
            prev_last = res_valid_out && res_last_out;
            prev_rv   = res_valid_out;
            prev_cv   = cba_valid_out;
            prev_g    = cur;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string n);
        chk({n, "_cba_valid"}, cba_valid_out, 0);
        chk({n, "_res_valid"}, res_valid_out, 0);
        chk({n, "_res_last"}, res_last_out, 0);
        chk({n, "_done"}, done_out, 0);
        chk({n, "_gate_err"}, gate_err_out, 0);
        chk({n, "_busy"}, busy_out, 0);
        chk({n, "_gates_done"}, gates_done_out, 0);
        chk({n, "_held"}, {cba_gate_type, cba_qubit_pos, cba_qubit_pos2}, 0);
        chk({n, "_cba_row"}, cba_row_out, 0);
        chk({n, "_res_row"}, res_row_out, 0);
        chk({n, "_gate_ready"}, gate_ready_out, 1);
        chk({n, "_tab_ready"}, tab_ready_out, 1);
    endtask

    task automatic load_tab(input logic [RW-1:0] r [NQ]);
        for (int i = 0; i < NQ; i++) begin
            tab_valid_in = 1'b1;
            tab_row_in   = r[i];
            tick();
        end
        tab_valid_in = 1'b0;
        exp_tab      = r;
        chk("load_tab_ready_hold", tab_ready_out, 0);
        chk("load_busy", busy_out, 1);
    endtask

    task automatic push_gate(input gate_t g, output logic err_seen, output logic acc);
        gate_valid_in = 1'b1;
        gate_type_in  = g.t;
        gate_pos_in   = g.p;
        gate_pos2_in  = g.p2;
        acc           = gate_ready_out;
        tick();
        gate_valid_in = 1'b0;
        err_seen      = gate_err_out;
        if (acc && legal(g)) ref_q.push_back(g);
    endtask

    task automatic push_chk(input gate_t g);
        logic e, a;
        push_gate(g, e, a);
        chk("gate_err", e, a && !legal(g));
    endtask

    task automatic start_run();
        base_iss  = iss_q.size();
        base_res  = res_q.size();
        base_done = done_cnt;
        start_in  = 1'b1;
        tick();
        start_in  = 1'b0;
    endtask

    task automatic finish_run(input string n);
        int k;
        for (k = 0; k < 3000 && done_cnt == base_done; k++) tick();
        chk({n, "_done_pulses"}, done_cnt - base_done, 1);
        tick();
        foreach (ref_q[j]) begin
            for (int i = 0; i < NQ; i++) exp_tab[i] = apply_row(exp_tab[i], ref_q[j]);
            chk({n, "_gate_order"}, (base_iss + j < iss_q.size()) ? iss_q[base_iss + j] : '1,
                ref_q[j]);
        end
        chk({n, "_issue_passes"}, iss_q.size() - base_iss, ref_q.size());
        chk({n, "_gates_done"}, gates_done_out, ref_q.size());
        chk({n, "_res_count"}, res_q.size() - base_res, NQ);
        for (int i = 0; i < NQ; i++) begin
            got_rows[i] = (base_res + i < res_q.size()) ? res_q[base_res + i] : 'x;
            chk({n, "_row"}, got_rows[i], exp_tab[i]);
            chk({n, "_last"}, (base_res + i < last_q.size()) ? last_q[base_res + i] : 1'bx,
                (i == NQ - 1));
        end
        chk({n, "_done_after_last"}, done_bad, 0);
        chk({n, "_held_stable"}, held_bad, 0);
        chk({n, "_cba_runlen"}, runlen_bad, 0);
        chk({n, "_res_runlen"}, resrun_bad, 0);
        chk({n, "_idle_busy"}, busy_out, 0);
        chk({n, "_idle_tab_ready"}, tab_ready_out, 1);
        ref_q.delete();
    endtask

    function automatic gate_t mk(input int t, input int p, input int p2);
        return '{t: 3'(t), p: 32'(p), p2: 32'(p2)};
    endfunction

    function automatic gate_t rand_gate();
        return mk($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4));
    endfunction

    initial begin : main
        logic [RW-1:0] zrows [NQ];
        logic [RW-1:0] rrows [NQ];
        vec_t          vecs [10];
        logic          e, a;
        int            errs, k, ng;

        for (int i = 0; i < NQ; i++) zrows[i] = RW'(1) << i;
        vecs[0] = '{g: mk(0, 0, 0), err: 1'b0};
        vecs[1] = '{g: mk(3, 0, 1), err: 1'b1};
        vecs[2] = '{g: mk(2, 2, 2), err: 1'b1};
        vecs[3] = '{g: mk(0, 4, 0), err: 1'b1};
        vecs[4] = '{g: mk(1, 3, 0), err: 1'b0};
        vecs[5] = '{g: mk(2, 1, 3), err: 1'b0};
        vecs[6] = '{g: mk(2, 0, 4), err: 1'b1};
        vecs[7] = '{g: mk(7, 1, 2), err: 1'b1};
        vecs[8] = '{g: '{t: 3'd0, p: 32'h8000_0000, p2: 32'd0}, err: 1'b1};
        vecs[9] = '{g: mk(2, 3, 0), err: 1'b0};

        rst = 1'b1; gate_valid_in = 1'b0; gate_type_in = '0; gate_pos_in = '0;
        gate_pos2_in = '0; tab_valid_in = 1'b0; tab_row_in = '0; start_in = 1'b0;
        stray_valid = 1'b0; stray_row = '0;
        tick();
        tick();
        reset_checks("reset");
        rst = 1'b0;
        tick();

        // Single Hadamard on qubit 0
        load_tab(zrows);
        push_chk(mk(0, 0, 0));
        start_run();
        finish_run("h1");
        chk("h1_type", iss_q[base_iss].t, 0);
        chk("h1_row0", got_rows[0], 9'h010);
        chk("h1_row1", got_rows[1], 9'h002);
        chk("h1_row2", got_rows[2], 9'h004);
        chk("h1_row3", got_rows[3], 9'h008);

        // Three gates queued while idle, before the tableau arrives
        push_chk(mk(0, 0, 0));
        push_chk(mk(2, 0, 1));
        push_chk(mk(1, 0, 0));
        load_tab(zrows);
        start_run();
        finish_run("three");
        chk("three_row0", got_rows[0], 9'h031);
        chk("three_row1", got_rows[1], 9'h003);
        chk("three_gates_done", gates_done_out, 3);

        // Illegal gates only: FIFO stays empty, tableau passes through unchanged
        load_tab(zrows);
        errs = 0;
        push_gate(mk(3, 0, 0), e, a); errs += int'(e);
        push_gate(mk(2, 2, 2), e, a); errs += int'(e);
        push_gate(mk(0, 4, 0), e, a); errs += int'(e);
        tick();
        chk("illegal_err_pulses", errs, 3);
        chk("illegal_err_cleared", gate_err_out, 0);
        chk("illegal_fifo_ready", gate_ready_out, 1);
        start_run();
        finish_run("illegal");

        // Table-driven legality vectors
        for (int i = 0; i < NQ; i++) rrows[i] = RW'($urandom);
        load_tab(rrows);
        foreach (vecs[i]) begin
            push_gate(vecs[i].g, e, a);
            chk("table_err", e, vecs[i].err);
        end
        start_run();
        finish_run("table");

        // FIFO full, then one more push while the run is draining the queue
        load_tab(zrows);
        for (int i = 0; i < GD; i++) push_chk(mk(i % 3, i % NQ, (i + 1) % NQ));
        chk("full_ready_low", gate_ready_out, 0);
        push_gate(mk(0, 1, 0), e, a);
        chk("full_ninth_refused", a, 0);
        chk("full_ninth_no_err", e, 0);
        start_run();
        for (k = 0; k < 200 && iss_q.size() == base_iss; k++) tick();
        push_gate(mk(1, 2, 0), e, a);
        chk("full_midrun_accept", a, 1);
        finish_run("full");
        chk("full_gates_done", gates_done_out, GD + 1);

        // Reset during the second COLLECT
        load_tab(zrows);
        push_chk(mk(0, 0, 0));
        push_chk(mk(2, 0, 1));
        push_chk(mk(1, 0, 0));
        start_run();
        for (k = 0; k < 500 && !(iss_q.size() >= base_iss + 2 && !cba_valid_out); k++) tick();
        chk("midrst_reached_collect2", iss_q.size() - base_iss, 2);
        #2;
        rst = 1'b1;
        tick();
        reset_checks("midrst");
        tick();
        rst = 1'b0;
        ref_q.delete();
        tick();
        tick();
        chk("midrst_no_done", done_cnt, base_done);
        load_tab(zrows);
        push_chk(mk(0, 0, 0));
        start_run();
        finish_run("post_rst");
        chk("post_rst_row0", got_rows[0], 9'h010);

        // Stray CBA row while holding must not touch the buffer
        for (int i = 0; i < NQ; i++) rrows[i] = RW'($urandom);
        load_tab(rrows);
        stray_valid = 1'b1;
        stray_row   = '1;
        tick();
        stray_valid = 1'b0;
        tick();
        start_run();
        finish_run("stray");

        // Randomized runs against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NQ; i++) rrows[i] = RW'($urandom);
            ng = $urandom_range(0, 10);
            if (r % 2 == 1) begin
                for (int i = 0; i < ng; i++) push_chk(rand_gate());
                load_tab(rrows);
            end else begin
                load_tab(rrows);
                for (int i = 0; i < ng; i++) push_chk(rand_gate());
            end
            start_run();
            finish_run("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_scheduler_cba.md
# gate_scheduler_cba

Sequences a queue of Clifford gates through the conjugation-by-action (CBA) datapath of the Heisenberg-picture emulator. Accepts and buffers one num_qubit-row stabilizer tableau and a FIFO of gates. On start, it streams the tableau through the CBA control/literal unit once per gate and writes the returned rows back into its buffer. After the last gate it drains the final tableau. It sits between the host-side gate/tableau loaders and the CBA unit, and filters illegal gates that would otherwise stall the CBA unit in its load state.

## Interface
- num_qubit, 4: qubits = tableau rows; ≥2
- gate_depth, 8: gate FIFO entries; power of two ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- gate_valid_in  in  1  gate push request
- gate_ready_out  out  1  FIFO not full
- gate_type_in  in  3  0 Hadamard, 1 Phase, 2 CNOT
- gate_pos_in  in  32  target qubit (H/P) or control qubit (CNOT)
- gate_pos2_in  in  32  CNOT target qubit
- gate_err_out  out  1  one-cycle pulse: last accepted gate was illegal and dropped
- tab_valid_in  in  1  tableau row valid
- tab_ready_out  out  1  row accepted this cycle
- tab_row_in  in  2*num_qubit+1  {phase, x[num_qubit-1:0], z[num_qubit-1:0]}
- start_in  in  1  begin execution (sampled in HOLD only)
- cba_valid_out  out  1  row valid to CBA unit
- cba_row_out  out  2*num_qubit+1  row to CBA unit
- cba_gate_type  out  3  held gate type
- cba_qubit_pos, cba_qubit_pos2  out  32  held gate positions
- cba_valid_in  in  1  row valid from CBA unit
- cba_row_in  in  2*num_qubit+1  updated row from CBA unit
- res_valid_out  out  1  final row valid (no backpressure)
- res_row_out  out  2*num_qubit+1  final row
- res_last_out  out  1  with final row num_qubit-1
- done_out  out  1  one-cycle pulse after last result row
- busy_out  out  1  state ≠ IDLE
- gates_done_out  out  16  gates executed this run

## Operation
- Gate intake (any state): push when gate_valid_in && gate_ready_out. The gate is legal iff type ≤2, pos < num_qubit, and, for CNOT, pos2 < num_qubit and pos2 ≠ pos. Legal gates are written to the FIFO. Illegal gates are consumed but not stored; gate_err_out pulses the next cycle.
- Row buffer: num_qubit entries, index 0..num_qubit-1, in order.
- IDLE: tab_ready_out=1. An accepted row is written to index 0 and the FSM moves to LOAD. gates_done_out clears to 0.
- LOAD: tab_ready_out=1. Rows fill indices 1..num_qubit-1. After row num_qubit-1 is accepted, go to HOLD.
- HOLD: tab_ready_out=0. On start_in: if FIFO is non-empty, go to ISSUE; if empty, go to DRAIN (tableau is output unchanged).
- ISSUE entry: pop the FIFO head into the held gate registers. Held fields stay stable through ISSUE and COLLECT.
- ISSUE: drive rows 0..num_qubit-1 on num_qubit consecutive cycles with cba_valid_out=1. Then go to COLLECT.
- COLLECT: each cba_valid_in writes cba_row_in to the next index from 0. After num_qubit rows, increment gates_done_out (saturating at 16'hFFFF). If the FIFO is non-empty, go to ISSUE (pop); otherwise go to DRAIN.
- Gates pushed during a run are executed in that run if present when COLLECT completes.
- DRAIN: output rows 0..num_qubit-1 on consecutive cycles, with res_last_out on the final row. The next cycle pulses done_out and enters IDLE.
- FIFO: simultaneous push and pop is allowed. Occupancy is unchanged when both occur. A pop never occurs on an empty FIFO. A push never occurs when full.
- cba_valid_in outside COLLECT is ignored.

## Timing
- All outputs are registered except gate_ready_out and tab_ready_out, which decode state/occupancy combinationally.
- Reset values:
  - all valid/pulse/last outputs 0
  - busy_out 0
  - gates_done_out 0
  - cba_gate_type, cba_qubit_pos, cba_qubit_pos2, cba_row_out, res_row_out all 0
  - FIFO empty; gate_ready_out=1
  - state IDLE; tab_ready_out=1
- Reset mid-run aborts everything: buffer contents are don't-care, FIFO is emptied, and no done_out is issued. The CBA unit shares rst.
- Held gate fields update the cycle ISSUE is entered. They are valid at least one cycle before the first cba_valid_out and remain stable until COLLECT exits.
- cba_valid_out is high for exactly num_qubit contiguous cycles per gate, starting the cycle after HOLD or COLLECT exits.
- Per-gate CBA latency is set by the CBA unit. The scheduler waits on cba_valid_in count only, with no timeout.
- res_valid_out rises the cycle after DRAIN is entered and stays high for num_qubit contiguous cycles.
- The first-gate pop uses occupancy sampled in HOLD or COLLECT's final cycle.

## Test plan
- Hadamard on one qubit (num_qubit=4): load rows Z0..Z3 (row i: z=1<<i, x=0, phase 0); push H pos 0; start.
  - Require cba_valid_out for 4 cycles with cba_gate_type=0.
  - Require row 0 out as x=0001, z=0000; rows 1..3 unchanged.
  - Require res_last_out on row 3, done_out one cycle later, gates_done_out=1.
- Three-gate sequence: push H0, CNOT(0,1), P0; load Z rows; start.
  - Require 3 ISSUE passes with held fields matching each gate.
  - Require final rows as Clifford reference: row0 x=0011 z=0001, row1 x=0000 z=0011.
  - Require gates_done_out=3.
- Illegal gates: push type 3; then CNOT(2,2); then H pos 4.
  - Require gate_err_out to pulse 3 times and the FIFO to remain empty.
  - With start, require DRAIN with the unchanged tableau and gates_done_out=0.
- FIFO full: push 8 legal gates; require gate_ready_out=0 on the 9th push.
  - Push one gate during the run while the FIFO is partially popped.
  - Require 9 gates executed in order.
- Reset mid-run: assert rst during the second COLLECT.
  - Require all outputs at reset values on the next edge and FIFO empty.
  - Require a subsequent full load and one H gate to complete correctly.
- Stray input: assert cba_valid_in during HOLD. Require the buffer to be unmodified, checked by DRAIN output.
